// File: rtl/result_collector.sv
// Assembles the 8-word Curve448 ladder result stream into a 448-bit value and
// hands it to the host over valid/ready, zeroing any frame that saw a fault.
module result_collector #(
   parameter int unsigned WORD_W    = 56,
   parameter int unsigned NUM_WORDS = 8,
   parameter int unsigned CNT_W     = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic [WORD_W-1:0]           in_data,
   input  logic                        in_error,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WORD_W*NUM_WORDS-1:0] out_data,
   output logic                        out_error,
   output logic                        overrun,
   output logic                        busy,
   output logic [CNT_W-1:0]            word_cnt
);

   localparam int unsigned OUT_W = WORD_W * NUM_WORDS;

   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

   state_t                              state_q, state_d;
   logic [NUM_WORDS-1:0][WORD_W-1:0]    asm_q, asm_d;
   logic [OUT_W-1:0]                    out_data_q, out_data_d;
   logic [CNT_W-1:0]                    word_cnt_q, word_cnt_d;
   logic                                err_acc_q, err_acc_d;
   logic                                out_valid_q, out_valid_d;
   logic                                out_error_q, out_error_d;
   logic                                overrun_q, overrun_d;
   logic                                busy_q, busy_d;

   // Next-state and output computation
   always_comb begin
      state_d     = state_q;
      asm_d       = asm_q;
      out_data_d  = out_data_q;
      word_cnt_d  = word_cnt_q;
      err_acc_d   = err_acc_q;
      out_valid_d = out_valid_q;
      out_error_d = out_error_q;
      overrun_d   = overrun_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               asm_d[0]   = in_data;
               word_cnt_d = CNT_W'(1);
               err_acc_d  = in_error;
               state_d    = COLLECT;
            end
         end
         COLLECT: begin
            // Faults count even on idle cycles between words
            err_acc_d = err_acc_q | in_error;
            if (in_valid) begin
               asm_d[word_cnt_q] = in_data;
               if (word_cnt_q == CNT_W'(NUM_WORDS - 1)) begin
                  state_d     = HOLD;
                  word_cnt_d  = '0;
                  out_valid_d = 1'b1;
                  out_error_d = err_acc_d;
                  out_data_d  = err_acc_d ? '0 : OUT_W'(asm_d);
               end else begin
                  word_cnt_d = word_cnt_q + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               out_error_d = 1'b0;
               out_data_d  = '0;
               err_acc_d   = 1'b0;
               asm_d       = '0;
               state_d     = IDLE;
               if (in_valid) begin
                  asm_d[0]   = in_data;
                  word_cnt_d = CNT_W'(1);
                  err_acc_d  = in_error;
                  state_d    = COLLECT;
               end
            end else if (in_valid) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == COLLECT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         asm_q       <= '0;
         out_data_q  <= '0;
         word_cnt_q  <= '0;
         err_acc_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_error_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         asm_q       <= asm_d;
         out_data_q  <= out_data_d;
         word_cnt_q  <= word_cnt_d;
         err_acc_q   <= err_acc_d;
         out_valid_q <= out_valid_d;
         out_error_q <= out_error_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_error = out_error_q;
   assign overrun   = overrun_q;
   assign busy      = busy_q;
   assign word_cnt  = word_cnt_q;

endmodule
